// File: rtl/pwm_freq_selector.sv
// pwm_freq_selector: glitch-free selection of one square-wave tap out of N_CH.
// A switch waits until the old tap is low, holds the output low, and then
// waits until the new tap is low before the new tap is handed to the output.
// This keeps the output from ever producing a shortened high pulse.
// Optional feature macro: PWM_FSW_TIMEOUT_EN. When it is defined, a switch
// that waits TIMEOUT cycles is forced through and flags Sw_timeout (sticky).
// When it is not defined, the wait states wait indefinitely, the wait counter
// is not built, and Sw_timeout is tied to 0.
module pwm_freq_selector #(
    parameter int N_CH    = 8,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_CH-1:0]  F_in,
    input  logic [SEL_W-1:0] Selector,
    output logic             Fsw,
    output logic             Busy,
    output logic             Sw_done,
    output logic             Sel_err,
    output logic             Sw_timeout
);

    typedef enum logic [1:0] {
        ST_RUN          = 2'd0,
        ST_WAIT_OLD_LOW = 2'd1,
        ST_WAIT_NEW_LOW = 2'd2
    } state_t;

    // Tap count widened by one bit so an all-ones selector can be range-checked.
    localparam logic [SEL_W:0] N_CH_L = N_CH[SEL_W:0];

    // Pick one tap out of the registered tap vector.
    function automatic logic tap_bit(input logic [N_CH-1:0]  taps_v,
                                     input logic [SEL_W-1:0] idx_v);
        logic bit_v;
        bit_v = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            bit_v = (idx_v == i[SEL_W-1:0]) ? taps_v[i] : bit_v;
        end
        return bit_v;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [N_CH-1:0]  f_q_r;
    logic [SEL_W-1:0] sel_q_r;
    logic [SEL_W-1:0] cur_sel_r;
    logic [SEL_W-1:0] cur_sel_nxt_s;
    logic [SEL_W-1:0] pend_r;
    logic [SEL_W-1:0] pend_nxt_s;
    logic             fsw_r;
    logic             fsw_nxt_s;
    logic             busy_r;
    logic             sw_done_r;
    logic             sw_done_nxt_s;
    logic             sel_err_r;
    logic             sel_err_nxt_s;
    logic             sel_in_range_s;
    logic             old_tap_s;
    logic             new_tap_s;

`ifdef PWM_FSW_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_L = TIMEOUT[15:0];

    logic [15:0]      wait_cnt_r;
    logic [15:0]      wait_cnt_nxt_s;
    logic             sw_timeout_r;
    logic             sw_timeout_nxt_s;
    logic             timed_out_s;
`endif

    // Decode the taps and selector seen by the FSM this cycle.
    always_comb begin
        sel_in_range_s = ({1'b0, sel_q_r} < N_CH_L);
        old_tap_s      = tap_bit(f_q_r, cur_sel_r);
        new_tap_s      = tap_bit(f_q_r, pend_r);
    end

`ifdef PWM_FSW_TIMEOUT_EN
    // A wait that has used up its budget is forced through.
    always_comb begin
        timed_out_s = (wait_cnt_r == TIMEOUT_L);
    end
`endif

    // Next-state and next-output logic of the switch FSM.
    always_comb begin
        state_nxt_s   = state_r;
        cur_sel_nxt_s = cur_sel_r;
        pend_nxt_s    = pend_r;
        fsw_nxt_s     = 1'b0;
        sw_done_nxt_s = 1'b0;
        sel_err_nxt_s = ~sel_in_range_s;
`ifdef PWM_FSW_TIMEOUT_EN
        wait_cnt_nxt_s   = wait_cnt_r;
        sw_timeout_nxt_s = sw_timeout_r;
`endif
        case (state_r)
            ST_RUN: begin
                fsw_nxt_s = old_tap_s;
                if (sel_in_range_s && (sel_q_r != cur_sel_r)) begin
                    pend_nxt_s  = sel_q_r;
                    state_nxt_s = ST_WAIT_OLD_LOW;
`ifdef PWM_FSW_TIMEOUT_EN
                    wait_cnt_nxt_s = 16'd0;
`endif
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT_OLD_LOW: begin
`ifdef PWM_FSW_TIMEOUT_EN
                wait_cnt_nxt_s = wait_cnt_r + 16'd1;
`endif
                if (!old_tap_s) begin
                    // Old tap has gone low: freeze the output low from here on.
                    fsw_nxt_s   = 1'b0;
                    state_nxt_s = ST_WAIT_NEW_LOW;
                end else begin
                    fsw_nxt_s   = old_tap_s;
                    state_nxt_s = ST_WAIT_OLD_LOW;
                end
`ifdef PWM_FSW_TIMEOUT_EN
                if (timed_out_s) begin
                    fsw_nxt_s        = 1'b0;
                    cur_sel_nxt_s    = pend_r;
                    sw_done_nxt_s    = 1'b1;
                    sw_timeout_nxt_s = 1'b1;
                    state_nxt_s      = ST_RUN;
                end else begin
                    sw_timeout_nxt_s = sw_timeout_r;
                end
`endif
            end
            ST_WAIT_NEW_LOW: begin
                fsw_nxt_s = 1'b0;
`ifdef PWM_FSW_TIMEOUT_EN
                wait_cnt_nxt_s = wait_cnt_r + 16'd1;
`endif
                if (!new_tap_s) begin
                    // New tap is low, so handing it over cannot cut a high phase.
                    cur_sel_nxt_s = pend_r;
                    sw_done_nxt_s = 1'b1;
                    state_nxt_s   = ST_RUN;
                end else begin
`ifdef PWM_FSW_TIMEOUT_EN
                    if (timed_out_s) begin
                        cur_sel_nxt_s    = pend_r;
                        sw_done_nxt_s    = 1'b1;
                        sw_timeout_nxt_s = 1'b1;
                        state_nxt_s      = ST_RUN;
                    end else begin
                        state_nxt_s = ST_WAIT_NEW_LOW;
                    end
`else
                    state_nxt_s = ST_WAIT_NEW_LOW;
`endif
                end
            end
            default: begin
                fsw_nxt_s   = 1'b0;
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Input capture, FSM state and registered outputs; reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= ST_RUN;
            f_q_r     <= '0;
            sel_q_r   <= '0;
            cur_sel_r <= '0;
            pend_r    <= '0;
            fsw_r     <= 1'b0;
            busy_r    <= 1'b0;
            sw_done_r <= 1'b0;
            sel_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            f_q_r     <= F_in;
            sel_q_r   <= Selector;
            cur_sel_r <= cur_sel_nxt_s;
            pend_r    <= pend_nxt_s;
            fsw_r     <= fsw_nxt_s;
            busy_r    <= (state_nxt_s != ST_RUN);
            sw_done_r <= sw_done_nxt_s;
            sel_err_r <= sel_err_nxt_s;
        end
    end

`ifdef PWM_FSW_TIMEOUT_EN
    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt_r   <= 16'd0;
            sw_timeout_r <= 1'b0;
        end else begin
            wait_cnt_r   <= wait_cnt_nxt_s;
            sw_timeout_r <= sw_timeout_nxt_s;
        end
    end

    assign Sw_timeout = sw_timeout_r;
`else
    assign Sw_timeout = 1'b0;
`endif

    assign Fsw     = fsw_r;
    assign Busy    = busy_r;
    assign Sw_done = sw_done_r;
    assign Sel_err = sel_err_r;

endmodule

// File: tb/tb_pwm_freq_selector.sv
// Scoreboard bench for pwm_freq_selector: directed stimulus pushes expected
// switch completions / selector errors into queues, a monitor pops them.
`timescale 1ns/1ps
module tb_pwm_freq_selector;

    typedef struct packed {
        logic [2:0] tap;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] f_in;
    logic [2:0] sel;
    logic [2:0] sel6;
    logic       fsw, busy, sw_done, sel_err, sw_to;
    logic       fsw6, busy6, sw_done6, sel_err6, sw_to6;

    logic [7:0] fin_h1 = 8'd0;
    logic [7:0] fin_h2 = 8'd0;
    logic       f_mode;
    logic [7:0] f_man;
    int unsigned tcnt;

    exp_t exp_q[$];
    logic err_q[$];
    int   checks = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   target = 0;
    logic pw_en = 1'b0;

    always #5 clk = ~clk;

    pwm_freq_selector #(.N_CH(8), .SEL_W(3), .TIMEOUT(20)) dut (
        .Clk(clk), .Reset(rst), .F_in(f_in), .Selector(sel),
        .Fsw(fsw), .Busy(busy), .Sw_done(sw_done), .Sel_err(sel_err),
        .Sw_timeout(sw_to));

    pwm_freq_selector #(.N_CH(6), .SEL_W(3), .TIMEOUT(20)) dut6 (
        .Clk(clk), .Reset(rst), .F_in(f_in[5:0]), .Selector(sel6),
        .Fsw(fsw6), .Busy(busy6), .Sw_done(sw_done6), .Sel_err(sel_err6),
        .Sw_timeout(sw_to6));

    // History of driven taps: fin_h2 is what the output should show in RUN.
    always @(posedge clk) begin
        fin_h1 <= f_in;
        fin_h2 <= fin_h1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tap k toggles every 2^(k+1) cycles.
    function automatic logic [7:0] taps(input int unsigned c);
        logic [7:0] t;
        for (int k = 0; k < 8; k++) t[k] = c[k+1];
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        tcnt++;
        f_in = f_mode ? f_man : taps(tcnt);
    endtask

    task automatic wait_done(input int tgt, input int bound, input string name);
        int n = 0;
        while (done_cnt < tgt && n < bound) begin
            tick();
            n++;
        end
        check(name, done_cnt, tgt);
    endtask

    task automatic wait_busy(input int bound);
        int n = 0;
        while (!busy && n < bound) begin
            tick();
            n++;
        end
        check("busy_seen", busy, 1);
    endtask

    // Monitor: pops the scoreboard on every completion / error pulse.
    initial begin
        exp_t e;
        logic eb;
        logic prev_fsw = 1'b0;
        logic armed = 1'b0;
        int   hi_run = 0;
        forever begin
            @(negedge clk);
            if (sw_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("sw_done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sw_done_tap", dut.cur_sel_r, e.tap);
                    check("sw_done_timeout_flag", sw_to, e.to);
                    check("busy_at_done", busy, 0);
                end
            end
            if (sel_err6) begin
                err_cnt++;
                if (err_q.size() == 0) begin
                    check("sel_err_unexpected", 1, 0);
                end else begin
                    eb = err_q.pop_front();
                    check("sel_err_busy", busy6, eb);
                end
            end
            if (sel_err) check("sel_err_dut8", sel_err, 0);
            if (sw_done6) check("sw_done6_unexpected", sw_done6, 0);
            if (fsw && !prev_fsw) begin
                hi_run = 1;
                armed  = pw_en;
            end else if (fsw) begin
                hi_run++;
            end else if (prev_fsw && armed && pw_en) begin
                check("fsw_min_high_ok", (hi_run >= 2), 1);
                armed = 1'b0;
            end else begin
                armed = armed;
            end
            prev_fsw = fsw;
        end
    end

    // Hang guard.
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        rst = 1'b1; f_mode = 1'b1; f_man = 8'hFF; f_in = 8'hFF;
        sel = 3'd0; sel6 = 3'd0; tcnt = 0;

        // Reset held 3 cycles with all taps high.
        repeat (3) tick();
        check("rst_fsw", fsw, 0);
        check("rst_busy", busy, 0);
        check("rst_sw_done", sw_done, 0);
        check("rst_sw_timeout", sw_to, 0);
        check("rst_cur_sel", dut.cur_sel_r, 0);
        check("rst_fsw6", fsw6, 0);
        rst = 1'b0;
        tick();
        check("release_fsw_cycle1", fsw, 0);
        tick();
        check("release_fsw_cycle2", fsw, 1);

        // Sweep 1..7 with toggling taps.
        f_mode = 1'b0;
        repeat (8) tick();
        pw_en = 1'b1;
        for (int k = 1; k < 8; k++) begin
            sel = k[2:0];
            exp_q.push_back('{tap: k[2:0], to: 1'b0});
            target++;
            wait_done(target, 2000, "sweep_done");
            tick();
            for (int j = 0; j < 4; j++) begin
                tick();
                check("fsw_follow", fsw, fin_h2[k]);
            end
        end

        // Selector changes while busy are deferred to a second switch.
        sel = 3'd1;
        exp_q.push_back('{tap: 3'd1, to: 1'b0});
        target++;
        wait_done(target, 2000, "to1_done");
        sel = 3'd2;
        exp_q.push_back('{tap: 3'd2, to: 1'b0});
        target++;
        wait_busy(50);
        sel = 3'd5;
        exp_q.push_back('{tap: 3'd5, to: 1'b0});
        target++;
        wait_done(target, 2000, "two_switches_done");
        repeat (20) tick();
        check("no_extra_done", done_cnt, target);
        check("idle_after_chain", busy, 0);
        pw_en = 1'b0;

        // Out-of-range selector on the 6-tap instance.
        sel6 = 3'd6;
        repeat (3) err_q.push_back(1'b0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("fsw6_tap0_oor", fsw6, fin_h2[0]);
        end
        sel6 = 3'd0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("fsw6_tap0_after", fsw6, fin_h2[0]);
            check("busy6_idle", busy6, 0);
        end
        check("sel_err_count", err_cnt, 3);
        check("dut6_cur_sel", dut6.cur_sel_r, 0);

        // Reset during WAIT_NEW_LOW: old tap 5 low, new tap 3 stuck high.
        f_mode = 1'b1; f_man = 8'b0000_1000; f_in = f_man;
        sel = 3'd3;
        wait_busy(10);
        tick();
        tick();
        check("in_wait_new_low", dut.state_r, 2);
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_fsw", fsw, 0);
        check("abort_cur_sel", dut.cur_sel_r, 0);
        check("abort_state", dut.state_r, 0);
        check("abort_no_done", done_cnt, target);
        rst = 1'b0;

        // New tap stuck high: forced switch or indefinite wait.
`ifdef PWM_FSW_TIMEOUT_EN
        exp_q.push_back('{tap: 3'd3, to: 1'b1});
        target++;
        wait_done(target, 100, "timeout_forced_done");
        tick();
        check("timeout_sticky", sw_to, 1);
        check("timeout_idle", busy, 0);
`else
        repeat (60) tick();
        check("stuck_busy", busy, 1);
        check("stuck_no_done", done_cnt, target);
        check("stuck_no_timeout", sw_to, 0);
`endif
        rst = 1'b1;
        tick();
        check("final_rst_timeout", sw_to, 0);
        rst = 1'b0;
        tick();
        check("exp_q_empty", exp_q.size(), 0);
        check("err_q_empty", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
